dsp_adder_pipe: RTL and testbench

Pipelined 32-bit add/subtract unit for the sail-core datapath. It is built on a single iCE40 SB_MAC16 configured as two cascaded 16-bit registered adders, with fabric logic for valid/ready flow control and flags. It accepts one operation per cycle and returns `a_in ± b_in` two clock edges later. It is intended for multi-cycle execute paths and address generation, where a registered DSP result frees LUTs and shortens the ALU critical path.

---
 rtl/dsp_adder_pipe.sv | 96 +++++++++
 tb/tb_dsp_adder_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_adder_pipe.sv
// Two-stage 32-bit add/subtract unit modelled on an SB_MAC16 used as two
// cascaded 16-bit registered adders, with fabric valid/ready and flag logic.
module dsp_adder_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic        sub_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] sum,
   output logic        carry_out,
   output logic        overflow,
   output logic        zero
);

   logic        en;

   logic [31:0] s1_a_q, s1_a_d;
   logic [31:0] s1_b_q, s1_b_d;
   logic        s1_sub_q, s1_sub_d;
   logic        s1_valid_q, s1_valid_d;

   logic [31:0] s2_sum_q, s2_sum_d;
   logic        s2_carry_q, s2_carry_d;
   logic        s2_ovf_q, s2_ovf_d;
   logic        s2_zero_q, s2_zero_d;
   logic        s2_valid_q, s2_valid_d;

   logic [16:0] lo_add;
   logic [16:0] hi_add;

   assign en       = !s2_valid_q || out_ready;
   assign in_ready = en;

   // Subtraction becomes A + ~B + 1 so the DSP only ever adds.
   always_comb begin
      s1_a_d     = a_in;
      s1_b_d     = sub_in ? ~b_in : b_in;
      s1_sub_d   = sub_in;
      s1_valid_d = in_valid;
   end

   // Bottom adder takes the op carry-in; top adder takes the bottom carry.
   always_comb begin
      lo_add     = {1'b0, s1_a_q[15:0]} + {1'b0, s1_b_q[15:0]}
                 + {16'd0, s1_sub_q};
      hi_add     = {1'b0, s1_a_q[31:16]} + {1'b0, s1_b_q[31:16]}
                 + {16'd0, lo_add[16]};
      s2_sum_d   = {hi_add[15:0], lo_add[15:0]};
      s2_carry_d = hi_add[16];
      s2_ovf_d   = (s1_a_q[31] == s1_b_q[31])
                 && (s2_sum_d[31] != s1_a_q[31]);
      s2_zero_d  = ~|s2_sum_d;
      s2_valid_d = s1_valid_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_sub_q   <= 1'b0;
         s1_valid_q <= 1'b0;
      end else if (en) begin
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_sub_q   <= s1_sub_d;
         s1_valid_q <= s1_valid_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_sum_q   <= '0;
         s2_carry_q <= 1'b0;
         s2_ovf_q   <= 1'b0;
         s2_zero_q  <= 1'b0;
         s2_valid_q <= 1'b0;
      end else if (en) begin
         s2_sum_q   <= s2_sum_d;
         s2_carry_q <= s2_carry_d;
         s2_ovf_q   <= s2_ovf_d;
         s2_zero_q  <= s2_zero_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign sum       = s2_sum_q;
   assign carry_out = s2_carry_q;
   assign overflow  = s2_ovf_q;
   assign zero      = s2_zero_q;

endmodule

// File: tb/tb_dsp_adder_pipe.sv
// Scoreboard bench for dsp_adder_pipe: driver pushes expected results,
// a negedge monitor pops and compares whenever a result is taken.
module tb_dsp_adder_pipe;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        v;
      logic        z;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        sub_in;
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        carry_out;
   logic        overflow;
   logic        zero;

   res_t q[$];
   int   total = 0;
   int   bad = 0;
   int   popped = 0;
   int   last_wait = 0;

   always #5 clk = ~clk;

   dsp_adder_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .a_in      (a_in),
      .b_in      (b_in),
      .sub_in    (sub_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic res_t model(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic s);
      res_t r;
      logic [32:0] t;
      if (!s) begin
         t = {1'b0, a} + {1'b0, b};
         r.v = (a[31] == b[31]) && (t[31] != a[31]);
      end else begin
         t[31:0] = a - b;
         t[32] = (a >= b);
         r.v = (a[31] != b[31]) && (t[31] != a[31]);
      end
      r.s = t[31:0];
      r.c = t[32];
      r.z = (t[31:0] == 32'd0);
      return r;
   endfunction

   // Present one op until accepted; expected result queued at acceptance.
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input res_t e);
      int n;
      n = 0;
      a_in = a;
      b_in = b;
      sub_in = s;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 20) begin
            chk("accept_timeout", 64'd0, 64'd1);
            break;
         end
      end
      last_wait = n;
      if (n <= 20) q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Monitor: compare taken results, and check held outputs during stalls.
   initial begin
      res_t held;
      res_t e;
      logic hv;
      hv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hv = 1'b0;
            continue;
         end
         if (hv)
            chk("stall_hold", {out_valid, sum, carry_out, overflow, zero},
                {1'b1, held});
         hv = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_out", {63'd0, out_valid}, 64'd0);
               end else begin
                  e = q.pop_front();
                  chk("result", {sum, carry_out, overflow, zero}, e);
                  popped++;
               end
            end else begin
               hv = 1'b1;
               held = {sum, carry_out, overflow, zero};
            end
         end
      end
   end

   initial begin
      int p0;
      logic [31:0] ra;
      logic [31:0] rb;
      logic rs;

      rst = 1'b1;
      a_in = '0;
      b_in = '0;
      sub_in = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_sum", {32'd0, sum}, 64'd0);
      chk("rst_flags", {61'd0, carry_out, overflow, zero}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      #16;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("no_spurious_valid", {63'd0, out_valid}, 64'd0);

      // Directed vectors with hand-computed results.
      issue(32'hFFFFFFFF, 32'h00000001, 1'b0, {32'h00000000, 3'b101});
      chk("lat_edge1", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("lat_edge2", {63'd0, out_valid}, 64'd1);
      issue(32'd5, 32'd7, 1'b1, {32'hFFFFFFFE, 3'b000});
      issue(32'h7FFFFFFF, 32'd1, 1'b0, {32'h80000000, 3'b010});
      issue(32'h80000000, 32'd1, 1'b1, {32'h7FFFFFFF, 3'b110});
      issue(32'd7, 32'd5, 1'b1, {32'h00000002, 3'b100});
      issue(32'd0, 32'd0, 1'b1, {32'h00000000, 3'b101});
      issue(32'h12345678, 32'h11111111, 1'b0, {32'h23456789, 3'b000});
      repeat (3) @(posedge clk);
      #1;
      chk("directed_drained", q.size(), 64'd0);

      // Streaming: 16 back-to-back ops.
      p0 = popped;
      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(1));
         issue(ra, rb, rs, model(ra, rb, rs));
         chk("stream_in_ready", last_wait, 64'd0);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("stream_count", popped - p0, 64'd16);

      // Backpressure: 3 ops with out_ready low.
      out_ready = 1'b0;
      p0 = popped;
      issue(32'd100, 32'd23, 1'b0, {32'd123, 3'b000});
      issue(32'd23, 32'd100, 1'b1, {32'hFFFFFFB3, 3'b000});
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      a_in = 32'd9;
      b_in = 32'd9;
      sub_in = 1'b1;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_high", {63'd0, in_ready}, 64'd1);
      q.push_back({32'd0, 3'b101});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("bp_count", popped - p0, 64'd3);
      chk("bp_drained", q.size(), 64'd0);

      // Reset mid-flight.
      out_ready = 1'b0;
      issue(32'd1, 32'd2, 1'b0, {32'd3, 3'b000});
      issue(32'd4, 32'd5, 1'b0, {32'd9, 3'b000});
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_sum", {32'd0, sum}, 64'd0);
      chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      q.delete();
      #3;
      rst = 1'b0;
      out_ready = 1'b1;
      p0 = popped;
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_silent", popped - p0, 64'd0);
      issue(32'hDEADBEEF, 32'h21524111, 1'b0, {32'h00000000, 3'b101});
      chk("post_rst_lat1", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("post_rst_lat2", {63'd0, out_valid}, 64'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_count", popped - p0, 64'd1);
      chk("final_drained", q.size(), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
